// File: rtl/cve2_pkg.sv
// Shared types for the CVE2 single-port OBI arbiter: requester IDs and selector states.
package cve2_pkg;

  typedef enum logic {OBI_SRC_INSTR, OBI_SRC_DATA} obi_src_e;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} obi_arb_state_e;

endpackage

// File: rtl/cve2_obi_src_fifo.sv
// Small FIFO of requester IDs, one entry per granted transaction awaiting its response.
module cve2_obi_src_fifo
  import cve2_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  obi_src_e push_src_i,
  input  logic     pop_i,
  output obi_src_e head_o,
  output logic     empty_o,
  output logic     full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  obi_src_e        mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DepthCnt);
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= OBI_SRC_INSTR;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_src_i;
        wr_ptr_q        <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (do_pop) rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) cnt_q <= cnt_q + CntW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: rtl/cve2_obi_arbiter.sv
// Two-to-one OBI arbiter sharing one memory port between instruction fetch and LSU,
// with address-phase locking and in-order response routing.
module cve2_obi_arbiter
  import cve2_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter logic        DataPriority   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        busy_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  obi_arb_state_e  state_q, state_d;
  obi_src_e        lock_src_q, lock_src_d;
  obi_src_e        rr_last_q;
  obi_src_e        sel_src, head_src;
  logic [CntW-1:0] count_q;
  logic            req_active, granted, resp_pop, fifo_empty, fifo_full;

  // Eligibility uses the registered count only, so rvalid never reaches mem_req_o.
  always_comb begin
    state_d    = state_q;
    lock_src_d = lock_src_q;
    sel_src    = OBI_SRC_INSTR;
    req_active = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if ((count_q < MaxCnt) && (instr_req_i || data_req_i)) begin
          req_active = 1'b1;
          if (DataPriority && data_req_i)      sel_src = OBI_SRC_DATA;
          else if (instr_req_i && data_req_i)  sel_src = (rr_last_q == OBI_SRC_DATA) ? OBI_SRC_INSTR
                                                                                     : OBI_SRC_DATA;
          else if (data_req_i)                 sel_src = OBI_SRC_DATA;
          else                                 sel_src = OBI_SRC_INSTR;
          if (!mem_gnt_i) begin
            state_d    = ARB_LOCKED;
            lock_src_d = sel_src;
          end
        end
      end
      ARB_LOCKED: begin
        req_active = 1'b1;
        sel_src    = lock_src_q;
        if (mem_gnt_i) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o   = req_active;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (req_active) begin
      if (sel_src == OBI_SRC_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = 4'hF;
        mem_addr_o  = instr_addr_i;
      end
    end
  end

  assign granted     = mem_gnt_i & req_active;
  assign instr_gnt_o = granted & (sel_src == OBI_SRC_INSTR);
  assign data_gnt_o  = granted & (sel_src == OBI_SRC_DATA);

  // Responses with nothing outstanding are dropped rather than misrouted.
  assign resp_pop       = mem_rvalid_i & ~fifo_empty;
  assign instr_rvalid_o = resp_pop & (head_src == OBI_SRC_INSTR);
  assign data_rvalid_o  = resp_pop & (head_src == OBI_SRC_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_err_o    = mem_err_i;
  assign data_err_o     = mem_err_i;
  assign busy_o         = (count_q != '0) | mem_req_o;

  cve2_obi_src_fifo #(
    .Depth(MaxOutstanding)
  ) u_src_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (granted),
    .push_src_i (sel_src),
    .pop_i      (resp_pop),
    .head_o     (head_src),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB_IDLE;
      lock_src_q <= OBI_SRC_INSTR;
      rr_last_q  <= OBI_SRC_DATA;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      lock_src_q <= lock_src_d;
      if (granted) rr_last_q <= sel_src;
      if (granted && !resp_pop) count_q <= count_q + CntW'(1);
      else if (resp_pop && !granted) count_q <= count_q - CntW'(1);
    end
  end

  a_req_known: assert property (@(posedge clk_i) disable iff (!rst_ni) !$isunknown(mem_req_o));
  a_payload_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_req_o |-> !$isunknown({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}));
  a_payload_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mem_req_o && !mem_gnt_i) |=> $stable({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}));
  a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= MaxCnt);
  a_full_push: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (granted && fifo_full) |-> resp_pop);
  a_spurious_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(mem_rvalid_i && fifo_empty)) else $warning("rvalid received with no outstanding transaction");

endmodule

// File: tb/tb_cve2_obi_arbiter.sv
// Directed bench: a fixed-priority and a round-robin arbiter share one stimulus stream.
module tb_cve2_obi_arbiter;
  import cve2_pkg::*;

  logic clk, rst_n;
  logic instr_req, data_req, data_we, mem_gnt, mem_rvalid, mem_err;
  logic [3:0]  data_be;
  logic [31:0] instr_addr, data_addr, data_wdata, mem_rdata;

  logic        p_igNT, p_ivld, p_ierr, p_dgnt, p_dvld, p_derr, p_req, p_we, p_busy;
  logic [31:0] p_irdata, p_drdata, p_addr, p_wdata;
  logic [3:0]  p_be;
  logic        r_igNT, r_ivld, r_ierr, r_dgnt, r_dvld, r_derr, r_req, r_we, r_busy;
  logic [31:0] r_irdata, r_drdata, r_addr, r_wdata;
  logic [3:0]  r_be;

  int n_pass = 0, n_total = 0, n_fail = 0;

  cve2_obi_arbiter #(.MaxOutstanding(2), .DataPriority(1'b1)) u_dut_pri (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_gnt_o(p_igNT), .instr_addr_i(instr_addr),
    .instr_rvalid_o(p_ivld), .instr_rdata_o(p_irdata), .instr_err_o(p_ierr),
    .data_req_i(data_req), .data_gnt_o(p_dgnt), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_rvalid_o(p_dvld), .data_rdata_o(p_drdata), .data_err_o(p_derr),
    .mem_req_o(p_req), .mem_gnt_i(mem_gnt), .mem_we_o(p_we), .mem_be_o(p_be),
    .mem_addr_o(p_addr), .mem_wdata_o(p_wdata), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .mem_err_i(mem_err), .busy_o(p_busy)
  );

  cve2_obi_arbiter #(.MaxOutstanding(2), .DataPriority(1'b0)) u_dut_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_gnt_o(r_igNT), .instr_addr_i(instr_addr),
    .instr_rvalid_o(r_ivld), .instr_rdata_o(r_irdata), .instr_err_o(r_ierr),
    .data_req_i(data_req), .data_gnt_o(r_dgnt), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_rvalid_o(r_dvld), .data_rdata_o(r_drdata), .data_err_o(r_derr),
    .mem_req_o(r_req), .mem_gnt_i(mem_gnt), .mem_we_o(r_we), .mem_be_o(r_be),
    .mem_addr_o(r_addr), .mem_wdata_o(r_wdata), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .mem_err_i(mem_err), .busy_o(r_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change at posedge+1; checks happen at the following negedge.
  task automatic settle;
    #4;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    instr_req = 0; data_req = 0; data_we = 0; data_be = 4'h0;
    instr_addr = 0; data_addr = 0; data_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    @(posedge clk); #1;
    settle();
    chk("reset_req", {31'b0, p_req}, 32'h0);
    chk("reset_busy", {30'b0, p_busy, r_busy}, 32'h0);
    chk("reset_gnt", {28'b0, p_igNT, p_dgnt, p_ivld, p_dvld}, 32'h0);
    chk("reset_payload", p_addr | p_wdata | {28'b0, p_be} | {31'b0, p_we}, 32'h0);
    next_cycle(); rst_n = 1;

    // Single instruction fetch with immediate grant, response next cycle.
    instr_req = 1; instr_addr = 32'h80; mem_gnt = 1;
    settle();
    chk("t1_req", {31'b0, p_req}, 32'h1);
    chk("t1_addr", p_addr, 32'h80);
    chk("t1_be", {28'b0, p_be}, 32'hF);
    chk("t1_we_wdata", p_wdata | {31'b0, p_we}, 32'h0);
    chk("t1_igNT", {30'b0, p_igNT, p_dgnt}, 32'h2);
    $display("t1 instr grant addr=%0h gnt=%0b", p_addr, p_igNT);
    next_cycle();
    instr_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h13;
    settle();
    chk("t1_rvalid", {30'b0, p_ivld, p_dvld}, 32'h2);
    chk("t1_rdata", p_irdata, 32'h13);
    $display("t1 response rvalid=%0b rdata=%0h", p_ivld, p_irdata);
    next_cycle();
    mem_rvalid = 0;
    settle();
    chk("t1_busy_after", {31'b0, p_busy}, 32'h0);

    // Both requesting with continuous grant: priority vs round-robin order.
    do_reset();
    instr_req = 1; data_req = 1; instr_addr = 32'h100; data_addr = 32'h400; mem_gnt = 1;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = (i != 0);
      settle();
      chk($sformatf("t2_pri_gnt%0d", i), {30'b0, p_igNT, p_dgnt}, 32'h1);
      chk($sformatf("t2_rr_gnt%0d", i), {30'b0, r_igNT, r_dgnt}, (i % 2 == 0) ? 32'h2 : 32'h1);
      if (i != 0) begin
        chk($sformatf("t2_pri_rsp%0d", i), {30'b0, p_ivld, p_dvld}, 32'h1);
        chk($sformatf("t2_rr_rsp%0d", i), {30'b0, r_ivld, r_dvld}, (i % 2 == 1) ? 32'h2 : 32'h1);
      end
      $display("t2 cycle %0d pri i/d=%0b%0b rr i/d=%0b%0b", i, p_igNT, p_dgnt, r_igNT, r_dgnt);
      next_cycle();
    end
    data_req = 0;
    settle();
    chk("t2_pri_instr_after", {30'b0, p_igNT, p_dgnt}, 32'h2);
    chk("t2_pri_instr_addr", p_addr, 32'h100);
    next_cycle();
    instr_req = 0; mem_gnt = 0;
    settle();
    chk("t2_pri_instr_rsp", {30'b0, p_ivld, p_dvld}, 32'h2);
    next_cycle();
    mem_rvalid = 0;

    // Address phase held for a stalled data request while instr arrives later.
    do_reset();
    data_req = 1; data_we = 1; data_be = 4'h3; data_addr = 32'h200; data_wdata = 32'hDEAD;
    instr_addr = 32'h84;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) instr_req = 1;
      settle();
      chk($sformatf("t3_hold_addr%0d", i), r_addr, 32'h200);
      chk($sformatf("t3_hold_we%0d", i), {31'b0, r_we}, 32'h1);
      chk($sformatf("t3_hold_gnt%0d", i), {30'b0, r_igNT, r_dgnt}, 32'h0);
      $display("t3 stall %0d addr=%0h we=%0b", i, r_addr, r_we);
      next_cycle();
    end
    mem_gnt = 1;
    settle();
    chk("t3_data_gnt", {30'b0, r_igNT, r_dgnt}, 32'h1);
    chk("t3_data_wdata", r_wdata, 32'hDEAD);
    next_cycle();
    data_req = 0;
    settle();
    chk("t3_instr_gnt", {30'b0, r_igNT, r_dgnt}, 32'h2);
    chk("t3_instr_payload", {r_addr[27:0], r_be}, {28'h84, 4'hF});
    chk("t3_instr_wdata", r_wdata, 32'h0);
    next_cycle();
    instr_req = 0; mem_gnt = 0;

    // Outstanding limit of two and in-order response routing.
    do_reset();
    instr_req = 1; instr_addr = 32'h100; mem_gnt = 1;
    settle();
    chk("t4_g0", {30'b0, p_igNT, p_dgnt}, 32'h2);
    next_cycle();
    instr_req = 0; data_req = 1; data_addr = 32'h300;
    settle();
    chk("t4_g1", {30'b0, p_igNT, p_dgnt}, 32'h1);
    next_cycle();
    settle();
    chk("t4_blocked_req", {31'b0, p_req}, 32'h0);
    chk("t4_blocked_gnt", {31'b0, p_dgnt}, 32'h0);
    chk("t4_blocked_busy", {31'b0, p_busy}, 32'h1);
    next_cycle();
    mem_rvalid = 1; mem_rdata = 32'hAA; mem_err = 1;
    settle();
    chk("t4_rsp0_route", {30'b0, p_ivld, p_dvld}, 32'h2);
    chk("t4_rsp0_err", {30'b0, p_ierr, p_derr}, 32'h3);
    chk("t4_same_cycle_req", {31'b0, p_req}, 32'h0);
    $display("t4 rsp0 instr=%0b data=%0b rdata=%0h", p_ivld, p_dvld, p_irdata);
    next_cycle();
    mem_rvalid = 0; mem_err = 0;
    settle();
    chk("t4_reopen_req", {31'b0, p_req}, 32'h1);
    chk("t4_reopen_gnt", {31'b0, p_dgnt}, 32'h1);
    next_cycle();
    data_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hBB;
    settle();
    chk("t4_rsp1_route", {30'b0, p_ivld, p_dvld}, 32'h1);
    chk("t4_rsp1_rdata", p_drdata, 32'hBB);
    $display("t4 rsp1 instr=%0b data=%0b rdata=%0h", p_ivld, p_dvld, p_drdata);
    next_cycle();
    mem_rvalid = 0;

    // Stray rvalid with nothing outstanding, then reset with two outstanding.
    do_reset();
    mem_rvalid = 1; mem_rdata = 32'h55;
    settle();
    chk("t5_stray_rvalid", {28'b0, p_ivld, p_dvld, r_ivld, r_dvld}, 32'h0);
    next_cycle();
    mem_rvalid = 0;
    settle();
    chk("t5_stray_busy", {30'b0, p_busy, r_busy}, 32'h0);
    instr_req = 1; instr_addr = 32'h10; mem_gnt = 1;
    next_cycle();
    next_cycle();
    instr_req = 0; mem_gnt = 0;
    settle();
    chk("t5_two_out_busy", {31'b0, p_busy}, 32'h1);
    chk("t5_two_out_req", {31'b0, p_req}, 32'h0);
    #2 rst_n = 0;
    #1;
    chk("t5_async_busy", {30'b0, p_busy, r_busy}, 32'h0);
    $display("t5 async reset busy=%0b", p_busy);
    next_cycle();
    rst_n = 1;
    mem_rvalid = 1;
    settle();
    chk("t5_forgotten_rsp", {30'b0, p_ivld, p_dvld}, 32'h0);
    next_cycle();
    mem_rvalid = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
